// File: rtl/ex_stage_unit_if.sv
// ex_stage_unit_if -- bundle of the ID/EX latch inputs and the EX results
// passed on to MEM. The ID side (or a testbench) uses the master modport and
// the execute stage uses the slave modport.
interface ex_stage_unit_if;
   logic [31:0] ir_i;   // instruction from ID
   logic [31:0] npc_i;  // PC+4 from ID
   logic [31:0] a_i;    // rs operand value
   logic [31:0] b_i;    // rt operand value
   logic [31:0] imm_i;  // sign-extended immediate
   logic        cond;   // registered branch-taken flag
   logic [31:0] alu_o;  // ALU result
   logic        zf_o;   // zero flag
   logic        of_o;   // signed overflow flag
   logic [31:0] b_o;    // latched rt value for stores
   logic [31:0] ir_o;   // latched instruction

   modport master (
      output ir_i, npc_i, a_i, b_i, imm_i,
      input  cond, alu_o, zf_o, of_o, b_o, ir_o
   );

   modport slave (
      input  ir_i, npc_i, a_i, b_i, imm_i,
      output cond, alu_o, zf_o, of_o, b_o, ir_o
   );
endinterface

// File: rtl/ex_stage_unit.sv
// ex_stage_unit -- execute stage of the 32-bit R/I/J CPU.
// Latches instruction/operands on the falling clock edge, decodes the
// latched instruction into a 3-bit ALU operation and evaluates the ALU
// combinationally. The branch condition is evaluated on the incoming
// operand and registered alongside the instruction.
// Optional feature: define EX_FLUSH_EN to add a flush input that loads a
// bubble (all-zero instruction and operands) instead of the incoming data.
module ex_stage_unit #(
   parameter int IMM_SHIFT = 2
) (
   input  logic clk,
   input  logic rst,
`ifdef EX_FLUSH_EN
   input  logic flush,
`endif
   ex_stage_unit_if.slave bus
);

   localparam logic [5:0] OPC_ALUR  = 6'h00;
   localparam logic [5:0] OPC_BEQZ  = 6'h04;
   localparam logic [5:0] OPC_BNEZ  = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_XOR  = 3'b010,
      ALU_NOR  = 3'b011,
      ALU_ADD  = 3'b100,
      ALU_SUB  = 3'b101,
      ALU_SLTU = 3'b110,
      ALU_SLLV = 3'b111
   } alu_op_e;

   logic [31:0] ir_q,   ir_d;
   logic [31:0] a_q,    a_d;
   logic [31:0] b_q,    b_d;    // ALU operand B (rt, immediate or shifted offset)
   logic [31:0] rt_q,   rt_d;   // raw rt value forwarded to MEM for stores
   logic        cond_q, cond_d;

   logic [5:0]  in_opcode;
   logic        in_is_alur;
   logic        in_is_branch;
   logic        in_taken;

   alu_op_e     alu_op;
   logic [31:0] alu_res;
   logic        alu_of;

   // Operand-select decode looks at the incoming instruction so the mux
   // choice always matches the instruction being latched.
   assign in_opcode    = bus.ir_i[31:26];
   assign in_is_alur   = (in_opcode == OPC_ALUR);
   assign in_is_branch = (in_opcode == OPC_BEQZ) || (in_opcode == OPC_BNEZ);
   assign in_taken     = ((in_opcode == OPC_BEQZ) && (bus.a_i == 32'd0)) ||
                         ((in_opcode == OPC_BNEZ) && (bus.a_i != 32'd0));

   // Next-state values for the ID/EX latch, including the optional bubble.
   always_comb begin
      ir_d   = bus.ir_i;
      a_d    = in_is_branch ? bus.npc_i : bus.a_i;
      b_d    = bus.imm_i;
      rt_d   = bus.b_i;
      cond_d = in_taken;
      if (in_is_alur) begin
         b_d = bus.b_i;
      end else if (in_is_branch) begin
         b_d = bus.imm_i << IMM_SHIFT;
      end
`ifdef EX_FLUSH_EN
      if (flush) begin
         ir_d   = 32'd0;
         a_d    = 32'd0;
         b_d    = 32'd0;
         rt_d   = 32'd0;
         cond_d = 1'b0;
      end
`endif
   end

   // Stage registers update on the falling edge; reset clears them at once.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         ir_q   <= 32'd0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         rt_q   <= 32'd0;
         cond_q <= 1'b0;
      end else begin
         ir_q   <= ir_d;
         a_q    <= a_d;
         b_q    <= b_d;
         rt_q   <= rt_d;
         cond_q <= cond_d;
      end
   end

   // ALU controller: map the latched opcode/funct to an ALU operation.
   always_comb begin
      alu_op = ALU_ADD;
      case (ir_q[31:26])
         OPC_ALUR: begin
            case (ir_q[5:0])
               6'h24:   alu_op = ALU_AND;
               6'h25:   alu_op = ALU_OR;
               6'h26:   alu_op = ALU_XOR;
               6'h27:   alu_op = ALU_NOR;
               6'h20:   alu_op = ALU_ADD;
               6'h22:   alu_op = ALU_SUB;
               6'h2B:   alu_op = ALU_SLTU;
               6'h04:   alu_op = ALU_SLLV;
               default: alu_op = ALU_ADD;
            endcase
         end
         OPC_ANDI:  alu_op = ALU_AND;
         OPC_ORI:   alu_op = ALU_OR;
         OPC_XORI:  alu_op = ALU_XOR;
         OPC_SLTIU: alu_op = ALU_SLTU;
         OPC_ADDI:  alu_op = ALU_ADD;
         default:   alu_op = ALU_ADD;   // lw, sw, branch target and unknown
      endcase
   end

   // ALU: result and signed-overflow flag from the latched operands.
   always_comb begin
      alu_res = 32'd0;
      alu_of  = 1'b0;
      case (alu_op)
         ALU_AND:  alu_res = a_q & b_q;
         ALU_OR:   alu_res = a_q | b_q;
         ALU_XOR:  alu_res = a_q ^ b_q;
         ALU_NOR:  alu_res = ~(a_q | b_q);
         ALU_ADD: begin
            alu_res = a_q + b_q;
            alu_of  = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
         end
         ALU_SUB: begin
            alu_res = a_q - b_q;
            alu_of  = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
         end
         ALU_SLTU: alu_res = {31'd0, (a_q < b_q)};
         ALU_SLLV: alu_res = b_q << a_q[4:0];
         default:  alu_res = 32'd0;
      endcase
   end

   assign bus.alu_o = alu_res;
   assign bus.zf_o  = (alu_res == 32'd0);
   assign bus.of_o  = alu_of;
   assign bus.b_o   = rt_q;
   assign bus.ir_o  = ir_q;
   assign bus.cond  = cond_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// tb_ex_stage_unit -- table-driven and randomized checks of ex_stage_unit
// against a behavioural model of the execute stage.
module tb_ex_stage_unit;

   logic clk;
   logic rst;
`ifdef EX_FLUSH_EN
   logic flush;
`endif

   ex_stage_unit_if bus ();

   ex_stage_unit #(.IMM_SHIFT(2)) dut (
      .clk  (clk),
      .rst  (rst),
`ifdef EX_FLUSH_EN
      .flush(flush),
`endif
      .bus  (bus.slave)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ir, npc, a, b, imm;
      logic [31:0] alu;
      logic        zf, of, cond;
      logic [31:0] bo;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: straight from the instruction-set rules, using wide
   // signed arithmetic to decide overflow.
   function automatic vec_t model(input logic [31:0] ir, npc, a, b, imm);
      vec_t        r;
      logic [5:0]  opc, fn;
      logic [31:0] x, y;
      longint      s;
      r.ir = ir; r.npc = npc; r.a = a; r.b = b; r.imm = imm;
      r.of = 1'b0;
      opc = ir[31:26];
      fn  = ir[5:0];
      if (opc == 6'h04 || opc == 6'h05) begin
         x = npc;
         y = imm * 32'd4;
      end else begin
         x = a;
         y = (opc == 6'h00) ? b : imm;
      end
      r.alu = x + y;
      s = longint'($signed(x)) + longint'($signed(y));
      r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (opc == 6'h00) begin
         case (fn)
            6'h24: begin r.alu = x & y;    r.of = 1'b0; end
            6'h25: begin r.alu = x | y;    r.of = 1'b0; end
            6'h26: begin r.alu = x ^ y;    r.of = 1'b0; end
            6'h27: begin r.alu = ~(x | y); r.of = 1'b0; end
            6'h22: begin
               r.alu = x - y;
               s = longint'($signed(x)) - longint'($signed(y));
               r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h2B: begin r.alu = (x < y) ? 32'd1 : 32'd0; r.of = 1'b0; end
            6'h04: begin r.alu = y * (32'd1 << x[4:0]); r.of = 1'b0; end
            default: ;
         endcase
      end else if (opc == 6'h0C) begin r.alu = x & y; r.of = 1'b0;
      end else if (opc == 6'h0D) begin r.alu = x | y; r.of = 1'b0;
      end else if (opc == 6'h0E) begin r.alu = x ^ y; r.of = 1'b0;
      end else if (opc == 6'h0B) begin r.alu = (x < y) ? 32'd1 : 32'd0; r.of = 1'b0;
      end
      r.zf   = (r.alu == 32'd0);
      r.cond = (opc == 6'h04 && a == 32'd0) || (opc == 6'h05 && a != 32'd0);
      r.bo   = b;
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] ir, npc, a, b, imm, alu,
                               input logic zf, of, cond, input logic [31:0] bo);
      vec_t v;
      v.ir = ir; v.npc = npc; v.a = a; v.b = b; v.imm = imm;
      v.alu = alu; v.zf = zf; v.of = of; v.cond = cond; v.bo = bo;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.ir_i  = v.ir;
      bus.npc_i = v.npc;
      bus.a_i   = v.a;
      bus.b_i   = v.b;
      bus.imm_i = v.imm;
   endtask

   // Drive after a rising edge, let one falling edge load, sample 1 after.
   task automatic apply(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      @(negedge clk); #1;
   endtask

   task automatic compare(input string tag, input vec_t e);
      chk({tag, ".alu"},  bus.alu_o, e.alu);
      chk({tag, ".zf"},   {31'd0, bus.zf_o}, {31'd0, e.zf});
      chk({tag, ".of"},   {31'd0, bus.of_o}, {31'd0, e.of});
      chk({tag, ".cond"}, {31'd0, bus.cond}, {31'd0, e.cond});
      chk({tag, ".b_o"},  bus.b_o, e.bo);
      chk({tag, ".ir_o"}, bus.ir_o, e.ir);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".alu"},  bus.alu_o, 32'd0);
      chk({tag, ".zf"},   {31'd0, bus.zf_o}, 32'd1);
      chk({tag, ".of"},   {31'd0, bus.of_o}, 32'd0);
      chk({tag, ".cond"}, {31'd0, bus.cond}, 32'd0);
      chk({tag, ".b_o"},  bus.b_o, 32'd0);
      chk({tag, ".ir_o"}, bus.ir_o, 32'd0);
   endtask

   initial begin
      vec_t v, e;
      logic [5:0] opcs [13];
      logic [5:0] fns  [10];
      opcs = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C,
               6'h0D, 6'h0E, 6'h0B, 6'h23, 6'h2B, 6'h3F};
      fns  = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04, 6'h3F, 6'h01};

      //            ir            npc        a             b           imm          alu          zf of cond b_o
      vecs.push_back(mk(32'h00221820, 32'h0,   32'd5,        32'd7,      32'h0,       32'd12,      0, 0, 0, 32'd7));
      vecs.push_back(mk(32'h00221820, 32'h0,   32'h7FFFFFFF, 32'd1,      32'h0,       32'h80000000,0, 1, 0, 32'd1));
      vecs.push_back(mk(32'h00221822, 32'h0,   32'd9,        32'd9,      32'h0,       32'd0,       1, 0, 0, 32'd9));
      vecs.push_back(mk(32'h00221822, 32'h0,   32'h80000000, 32'd1,      32'h0,       32'h7FFFFFFF,0, 1, 0, 32'd1));
      vecs.push_back(mk(32'h3400000F, 32'h0,   32'hF0,       32'h1234,   32'h0F,      32'hFF,      0, 0, 0, 32'h1234));
      vecs.push_back(mk(32'h2C00FFFF, 32'h0,   32'd3,        32'h55,     32'hFFFFFFFF,32'd1,       0, 0, 0, 32'h55));
      vecs.push_back(mk(32'h1000FFFE, 32'h100, 32'd0,        32'h77,     32'hFFFFFFFE,32'hF8,      0, 0, 1, 32'h77));
      vecs.push_back(mk(32'h1000FFFE, 32'h100, 32'd1,        32'h77,     32'hFFFFFFFE,32'hF8,      0, 0, 0, 32'h77));
      vecs.push_back(mk(32'h1400FFFE, 32'h100, 32'd1,        32'h77,     32'hFFFFFFFE,32'hF8,      0, 0, 1, 32'h77));
      vecs.push_back(mk(32'h00000004, 32'h0,   32'd4,        32'd3,      32'h0,       32'h30,      0, 0, 0, 32'd3));
      vecs.push_back(mk(32'h0000003F, 32'h0,   32'd5,        32'd6,      32'h0,       32'd11,      0, 0, 0, 32'd6));
      vecs.push_back(mk(32'h00000027, 32'h0,   32'd0,        32'd0,      32'h0,       32'hFFFFFFFF,0, 0, 0, 32'd0));

      // Reset held while the clock runs with arbitrary inputs.
      rst = 1'b0;
`ifdef EX_FLUSH_EN
      flush = 1'b0;
`endif
      drive(mk(32'h00221820, 32'h44, 32'h7FFFFFFF, 32'd1, 32'h1, 32'h0, 0, 0, 0, 32'h0));
      repeat (3) @(negedge clk);
      #1;
      chk_reset_state("reset_hold");
      $display("txn reset_hold alu=%h zf=%b", bus.alu_o, bus.zf_o);
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed vectors from the table.
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         compare($sformatf("vec%0d", i), vecs[i]);
         $display("txn vec%0d ir=%h alu=%h zf=%b of=%b cond=%b", i,
                  bus.ir_o, bus.alu_o, bus.zf_o, bus.of_o, bus.cond);
      end

      // Reset asserted between edges clears outputs immediately.
      apply(vecs[0]);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk_reset_state("reset_mid");
      $display("txn reset_mid alu=%h ir=%h", bus.alu_o, bus.ir_o);
      @(posedge clk); #1;
      rst = 1'b1;
      apply(vecs[1]);
      compare("after_reset", vecs[1]);
      $display("txn after_reset alu=%h of=%b", bus.alu_o, bus.of_o);

`ifdef EX_FLUSH_EN
      // Flush overrides the incoming instruction with a bubble.
      @(posedge clk); #1;
      flush = 1'b1;
      drive(vecs[6]);
      @(negedge clk); #1;
      chk("flush.ir_o", bus.ir_o, 32'd0);
      chk("flush.alu",  bus.alu_o, 32'd0);
      chk("flush.cond", {31'd0, bus.cond}, 32'd0);
      $display("txn flush ir=%h alu=%h", bus.ir_o, bus.alu_o);
      @(posedge clk); #1;
      flush = 1'b0;
      apply(vecs[6]);
      compare("after_flush", vecs[6]);
`endif

      // Randomized instructions against the behavioural model.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ir, a;
         ir = $urandom;
         ir[31:26] = opcs[$urandom_range(0, 12)];
         if (ir[31:26] == 6'h00) ir[5:0] = fns[$urandom_range(0, 9)];
         a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         e = model(ir, $urandom, a, $urandom, $urandom);
         apply(e);
         compare($sformatf("rnd%0d", i), e);
         $display("txn rnd%0d ir=%h alu=%h exp=%h", i, bus.ir_o, bus.alu_o, e.alu);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
